// File: rtl/dct_feed_pkg.sv
// Shared constants and types for the DCT block feeder.
package dct_feed_pkg;

    localparam int unsigned DEF_PIXEL_BITS   = 10;
    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned DEF_BLOCK_N      = 8;
    localparam int unsigned DEF_NUM_CHANNELS = 3;
    localparam int unsigned DEF_FIFO_DEPTH   = 4;

    localparam int unsigned BLOCK_NUM_W = 16;
    localparam int unsigned SEQ_W       = 8;

    typedef enum logic [1:0] {
        CH_Y  = 2'd0,
        CH_CB = 2'd1,
        CH_CR = 2'd2
    } channel_e;

    // Sequencer state: the channel id expected next (EXPECT_0 .. EXPECT_{N-1}).
    typedef logic [SEQ_W-1:0] seq_state_t;
    localparam seq_state_t EXPECT_0 = '0;

    // Channel expected after a block carrying channel ch.
    function automatic seq_state_t seq_after(input logic [31:0] ch, input int unsigned n);
        return seq_state_t'((ch + 32'd1) % n);
    endfunction

endpackage

// File: rtl/dct_block_fifo.sv
// First-word fall-through block FIFO with registered ready/valid and level.
module dct_block_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             wr_ready,
    output logic             rd_valid
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_d;
    logic [LW-1:0]    level_d;

    // Next pointer/level values; flush wins over any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        level_d  = level;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_d = level + LW'(1);
                2'b01:   level_d = level - LW'(1);
                default: level_d = level;
            endcase
        end
    end

    // Pointer, level and handshake registers; ready stays low while in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_d;
            rd_ptr   <= rd_ptr_d;
            level    <= level_d;
            wr_ready <= (level_d < LW'(DEPTH));
            rd_valid <= (level_d != '0);
        end
    end

    // Slot storage, intentionally not reset.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/dct_block_feeder.sv
// Buffers pixel blocks for the DCT: level shift, channel-order check, block numbering.
module dct_block_feeder
    import dct_feed_pkg::*;
#(
    parameter  int unsigned PIXEL_BITS   = DEF_PIXEL_BITS,
    parameter  int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter  int unsigned BLOCK_N      = DEF_BLOCK_N,
    parameter  int unsigned NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter  int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    localparam int unsigned CW           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int unsigned LW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic                                             flush,
    input  logic                                             level_shift_en,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic [CW-1:0]                                    in_channel,
    input  logic [BLOCK_N-1:0][BLOCK_N-1:0][PIXEL_BITS-1:0]  in_data,
    output logic                                             out_valid,
    input  logic                                             out_ready,
    output logic [CW-1:0]                                    out_channel,
    output logic [BLOCK_NUM_W-1:0]                           out_block_num,
    output logic [BLOCK_N-1:0][BLOCK_N-1:0][DATA_WIDTH-1:0]  out_data,
    output logic [LW-1:0]                                    level,
    output logic                                             seq_err
);

    localparam int unsigned SAMPLES_W = BLOCK_N * BLOCK_N * DATA_WIDTH;
    localparam int unsigned PAY_W     = BLOCK_NUM_W + CW + SAMPLES_W;
    localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(1) << (PIXEL_BITS - 1);

    logic                                            accept;
    logic                                            pop;
    logic                                            ch_mismatch;
    logic [BLOCK_NUM_W-1:0]                          block_cnt;
    seq_state_t                                      seq_q;
    seq_state_t                                      seq_d;
    logic                                            seq_err_d;
    logic [BLOCK_N-1:0][BLOCK_N-1:0][DATA_WIDTH-1:0] shifted;
    logic [PAY_W-1:0]                                payload;
    logic [PAY_W-1:0]                                head;

    assign accept      = in_valid & in_ready & ~flush;
    assign pop         = out_valid & out_ready & ~flush;
    assign ch_mismatch = (32'(in_channel) != 32'(seq_q));

    // Widen samples, optionally re-centring them around zero.
    always_comb begin
        shifted = '0;
        for (int r = 0; r < int'(BLOCK_N); r++) begin
            for (int c = 0; c < int'(BLOCK_N); c++) begin
                shifted[r][c] = level_shift_en ? (DATA_WIDTH'(in_data[r][c]) - MID)
                                               : DATA_WIDTH'(in_data[r][c]);
            end
        end
    end

    // Block sequence number; deliberately survives flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            block_cnt <= '0;
        end else if (accept) begin
            block_cnt <= block_cnt + BLOCK_NUM_W'(1);
        end
    end

    // Channel sequencer state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seq_q   <= EXPECT_0;
            seq_err <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            seq_err <= seq_err_d;
        end
    end

    // Channel sequencer next state: advance on match, resync after an unexpected id.
    always_comb begin
        seq_d     = seq_q;
        seq_err_d = seq_err;
        if (flush) begin
            seq_d     = EXPECT_0;
            seq_err_d = 1'b0;
        end else if (accept) begin
            if (ch_mismatch) begin
                seq_err_d = 1'b1;
                seq_d     = seq_after(32'(in_channel), NUM_CHANNELS);
            end else if (32'(seq_q) == NUM_CHANNELS - 1) begin
                seq_d = EXPECT_0;
            end else begin
                seq_d = seq_q + SEQ_W'(1);
            end
        end
    end

    assign payload = {block_cnt, in_channel, shifted};

    dct_block_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAY_W)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .push     (accept),
        .pop      (pop),
        .wr_data  (payload),
        .rd_data  (head),
        .level    (level),
        .wr_ready (in_ready),
        .rd_valid (out_valid)
    );

    assign out_block_num = head[PAY_W-1 -: BLOCK_NUM_W];
    assign out_channel   = head[SAMPLES_W +: CW];
    assign out_data      = head[SAMPLES_W-1:0];

endmodule
